// File: rtl/delay_measure.sv
// delay_measure: measures the number of clock cycles between successive Tick events
module delay_measure #(
  parameter int NumberOfBits = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    Tick,
  output logic [NumberOfBits-1:0] Period,
  output logic                    Valid,
  output logic                    Overflow,
  output logic                    Measuring
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [NumberOfBits:0] ZERO = '0;
  localparam logic [NumberOfBits:0] ONE  = {{NumberOfBits{1'b0}}, 1'b1};
  localparam logic [NumberOfBits:0] FULL = {1'b1, {NumberOfBits{1'b0}}};
  logic [1:0]              state;
  logic [NumberOfBits:0]   cnt;
  assign Measuring = state == MEASURE;
  // Interval state machine; Enable=0 clears everything except Period and wins over Tick/overflow
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state    <= IDLE;
      cnt      <= ZERO;
      Period   <= '0;
      Valid    <= 1'b0;
      Overflow <= 1'b0;
    end else if (!Enable) begin
      state    <= IDLE;
      cnt      <= ZERO;
      Valid    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          state <= ARM;
          cnt   <= ZERO;
        end
        ARM: begin
          state <= Tick ? MEASURE : ARM;
          cnt   <= Tick ? ONE : ZERO;
        end
        MEASURE:
          if (Tick) begin
            Period <= cnt[NumberOfBits-1:0];
            Valid  <= 1'b1;
            cnt    <= ONE;
          end else if (cnt == FULL) begin
            Overflow <= 1'b1;
            cnt      <= ZERO;
            state    <= ARM;
          end else
            cnt <= cnt + ONE;
        default: begin
          state <= IDLE;
          cnt   <= ZERO;
        end
      endcase
    end
endmodule

// File: tb/tb_delay_measure.sv
// tb_delay_measure: directed scoreboard bench for delay_measure (NumberOfBits=4)
module tb_delay_measure;
  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b0;
  logic       Tick = 1'b0;
  logic [3:0] Period;
  logic       Valid, Overflow, Measuring;
  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  delay_measure #(.NumberOfBits(4)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Tick(Tick),
    .Period(Period), .Valid(Valid), .Overflow(Overflow), .Measuring(Measuring)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input int p, input int v, input int o, input int m);
    chk({tag, ".period"}, 32'(Period), 32'(p));
    chk({tag, ".valid"}, 32'(Valid), 32'(v));
    chk({tag, ".overflow"}, 32'(Overflow), 32'(o));
    chk({tag, ".measuring"}, 32'(Measuring), 32'(m));
  endtask

  // drive one cycle; p>=0 queues the Period expected with the Valid pulse after this edge
  task automatic cyc(input bit en, input bit t, input int p);
    bit want;
    Enable = en;
    Tick = t;
    if (p >= 0) exp_q.push_back(p);
    want = exp_q.size() > 0;
    @(posedge Clock);
    #1;
    chk("valid", 32'(Valid), 32'(want));
    if (want) chk("period", 32'(Period), 32'(exp_q.pop_front()));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, -1);
  endtask

  initial begin
    #3;
    outs("reset", 0, 0, 0, 0);
    Enable = 1'b1;
    Tick = 1'b1;
    @(posedge Clock); #1;
    outs("reset_hold1", 0, 0, 0, 0);
    @(posedge Clock); #1;
    outs("reset_hold2", 0, 0, 0, 0);
    Reset = 1'b0;
    // continuous ticks
    cyc(1, 0, -1);
    chk("arm.measuring", 32'(Measuring), 0);
    cyc(1, 1, -1);
    chk("first_tick.measuring", 32'(Measuring), 1);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1);
    chk("cont.overflow", 32'(Overflow), 0);
    cyc(0, 0, -1);
    outs("disable", 1, 0, 0, 0);
    // tick every 5 cycles
    cyc(1, 0, -1);
    cyc(1, 1, -1);
    chk("p5.measuring", 32'(Measuring), 1);
    for (int r = 0; r < 3; r++) begin
      idle_cycles(4);
      cyc(1, 1, 5);
    end
    // 16-cycle interval is a valid Period=0, then 3
    idle_cycles(15);
    cyc(1, 1, 0);
    chk("p16.overflow", 32'(Overflow), 0);
    idle_cycles(2);
    cyc(1, 1, 3);
    // overflow after 16 tickless edges
    idle_cycles(15);
    outs("pre_ovf", 3, 0, 0, 1);
    cyc(1, 0, -1);
    outs("ovf", 3, 0, 1, 0);
    cyc(1, 1, -1);
    idle_cycles(6);
    cyc(1, 1, 7);
    chk("sticky.overflow", 32'(Overflow), 1);
    // Enable=0 together with a measuring tick
    idle_cycles(4);
    cyc(0, 1, -1);
    outs("dis_tick", 7, 0, 0, 0);
    // async reset mid-measure
    cyc(1, 0, -1);
    cyc(1, 1, -1);
    idle_cycles(4);
    cyc(1, 1, 5);
    idle_cycles(2);
    outs("pre_rst", 5, 0, 0, 1);
    #2 Reset = 1'b1;
    #1;
    outs("async_rst", 0, 0, 0, 0);
    #1 Reset = 1'b0;
    cyc(1, 0, -1);
    chk("resume.arm", 32'(Measuring), 0);
    cyc(1, 1, -1);
    chk("resume.measure", 32'(Measuring), 1);
    idle_cycles(2);
    cyc(1, 1, 3);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
